// File: rtl/hpi_pkg.sv
// Shared definitions for the HPI burst master: FSM states, HPI register
// selects and default bus-cycle timing.
package hpi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HRST,
        S_WAIT_WR,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_RECOV
    } hpi_state_e;

    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDR    = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    localparam int unsigned DEF_SETUP_CYC  = 1;
    localparam int unsigned DEF_STROBE_CYC = 4;
    localparam int unsigned DEF_HOLD_CYC   = 1;
    localparam int unsigned DEF_RECOV_CYC  = 2;
    localparam int unsigned DEF_RST_CYC    = 16;

    localparam int unsigned TMR_W = 16;

endpackage

// File: rtl/hpi_cycle_timer.sv
// Loadable down-counter used to time every bus phase; done is high while the
// count is zero.
module hpi_cycle_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/hpi_burst_master.sv
// Command-driven CY7C67200 HPI bus-cycle engine: timed read/write bursts and
// the HPI chip reset pulse, with all pin outputs registered.
module hpi_burst_master
    import hpi_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
    parameter int unsigned STROBE_CYC = DEF_STROBE_CYC,
    parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
    parameter int unsigned RECOV_CYC  = DEF_RECOV_CYC,
    parameter int unsigned RST_CYC    = DEF_RST_CYC
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [1:0]        cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    input  logic              hpi_rst_req,
    output logic              busy,
    output logic [1:0]        otg_hpi_address_export,
    output logic              otg_hpi_cs_export,
    output logic              otg_hpi_r_export,
    output logic              otg_hpi_w_export,
    output logic              otg_hpi_reset_export,
    input  logic [DATA_W-1:0] otg_hpi_data_in_port,
    output logic [DATA_W-1:0] otg_hpi_data_out_port,
    output logic              otg_hpi_data_oe
);

    localparam logic [TMR_W-1:0] T_SETUP  = TMR_W'(SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] T_STROBE = TMR_W'(STROBE_CYC - 1);
    localparam logic [TMR_W-1:0] T_HOLD   = TMR_W'(HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] T_RECOV  = TMR_W'(RECOV_CYC - 1);
    localparam logic [TMR_W-1:0] T_RST    = TMR_W'(RST_CYC - 1);

    hpi_state_e        state, state_nxt;
    logic              dir_wr, dir_nxt;
    logic              accept;
    logic [LEN_W:0]    words_left;
    logic              tmr_load, tmr_done;
    logic [TMR_W-1:0]  tmr_val;
    logic              cs_active_nxt;
    logic              rd_capture;

    hpi_cycle_timer #(.W(TMR_W)) u_timer (
        .clk      (clk_clk),
        .rst      (reset_reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign cmd_ready  = (state == S_IDLE) & ~hpi_rst_req & ~reset_reset;
    assign wr_ready   = (state == S_WAIT_WR);
    assign busy       = (state != S_IDLE);
    assign rd_capture = (state == S_STROBE) & tmr_done & ~dir_wr;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir_wr;
        accept    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (hpi_rst_req) begin
                    state_nxt = S_HRST;
                end else if (cmd_valid) begin
                    accept    = 1'b1;
                    dir_nxt   = cmd_write;
                    state_nxt = cmd_write ? S_WAIT_WR : S_SETUP;
                end
            end
            S_HRST:    if (tmr_done) state_nxt = S_IDLE;
            S_WAIT_WR: if (wr_valid) state_nxt = S_SETUP;
            S_SETUP:   if (tmr_done) state_nxt = S_STROBE;
            S_STROBE:  if (tmr_done) state_nxt = S_HOLD;
            S_HOLD:    if (tmr_done) state_nxt = S_RECOV;
            S_RECOV: begin
                // Reads hold off the next strobe until the previous word is taken.
                if (tmr_done) begin
                    if (words_left == '0) begin
                        state_nxt = S_IDLE;
                    end else if (dir_wr) begin
                        state_nxt = S_WAIT_WR;
                    end else if (!(rd_valid && !rd_ready)) begin
                        state_nxt = S_SETUP;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        tmr_load = (state_nxt != state);
        unique case (state_nxt)
            S_HRST:   tmr_val = T_RST;
            S_SETUP:  tmr_val = T_SETUP;
            S_STROBE: tmr_val = T_STROBE;
            S_HOLD:   tmr_val = T_HOLD;
            S_RECOV:  tmr_val = T_RECOV;
            default:  tmr_val = '0;
        endcase

        cs_active_nxt = (state_nxt == S_SETUP) || (state_nxt == S_STROBE) ||
                        (state_nxt == S_HOLD);
    end

    // Pin outputs are decoded from the next state so they switch exactly on entry.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            dir_wr                 <= 1'b0;
            words_left             <= '0;
            otg_hpi_address_export <= '0;
            otg_hpi_data_out_port  <= '0;
            otg_hpi_cs_export      <= 1'b1;
            otg_hpi_r_export       <= 1'b1;
            otg_hpi_w_export       <= 1'b1;
            otg_hpi_reset_export   <= 1'b1;
            otg_hpi_data_oe        <= 1'b0;
            rd_valid               <= 1'b0;
            rd_data                <= '0;
        end else begin
            dir_wr <= dir_nxt;

            if (accept) begin
                otg_hpi_address_export <= cmd_addr;
                words_left             <= {1'b0, cmd_len} + (LEN_W+1)'(1);
            end else if (state == S_HOLD && tmr_done) begin
                words_left <= words_left - (LEN_W+1)'(1);
            end

            if (state == S_WAIT_WR && wr_valid) begin
                otg_hpi_data_out_port <= wr_data;
            end

            if (rd_capture) begin
                rd_data  <= otg_hpi_data_in_port;
                rd_valid <= 1'b1;
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
            end

            otg_hpi_cs_export    <= ~cs_active_nxt;
            otg_hpi_r_export     <= ~((state_nxt == S_STROBE) && !dir_nxt);
            otg_hpi_w_export     <= ~((state_nxt == S_STROBE) && dir_nxt);
            otg_hpi_reset_export <= ~(state_nxt == S_HRST);
            otg_hpi_data_oe      <= cs_active_nxt && dir_nxt;
        end
    end

endmodule

// File: tb/tb_hpi_burst_master.sv
// Directed bench for hpi_burst_master: a negedge pin monitor plus a simple
// HPI read-data model returning 0xA000 + strobe index.
module tb_hpi_burst_master;
    import hpi_pkg::*;

    logic        clk;
    logic        reset_reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [1:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [15:0] wr_data;
    logic        rd_valid, rd_ready;
    logic [15:0] rd_data;
    logic        hpi_rst_req, busy;
    logic [1:0]  hpi_addr;
    logic        hpi_cs, hpi_r, hpi_w, hpi_rst;
    logic [15:0] hpi_din, hpi_dout;
    logic        hpi_oe;

    hpi_burst_master dut (
        .clk_clk                (clk),
        .reset_reset            (reset_reset),
        .cmd_valid              (cmd_valid),
        .cmd_ready              (cmd_ready),
        .cmd_write              (cmd_write),
        .cmd_addr               (cmd_addr),
        .cmd_len                (cmd_len),
        .wr_valid               (wr_valid),
        .wr_ready               (wr_ready),
        .wr_data                (wr_data),
        .rd_valid               (rd_valid),
        .rd_ready               (rd_ready),
        .rd_data                (rd_data),
        .hpi_rst_req            (hpi_rst_req),
        .busy                   (busy),
        .otg_hpi_address_export (hpi_addr),
        .otg_hpi_cs_export      (hpi_cs),
        .otg_hpi_r_export       (hpi_r),
        .otg_hpi_w_export       (hpi_w),
        .otg_hpi_reset_export   (hpi_rst),
        .otg_hpi_data_in_port   (hpi_din),
        .otg_hpi_data_out_port  (hpi_dout),
        .otg_hpi_data_oe        (hpi_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        mon_clr;
    logic [1:0]  exp_addr;
    int          cs_pulses, cs_low_total, cs_high_run, min_gap;
    int          w_low_total, r_low_total, rst_low_total, busy_cycles;
    int          both_low, rw_out, oe_bad, addr_bad, rd_cnt;
    logic        cs_prev, r_prev, w_seen;
    logic [15:0] w_first, w_last, rd_idx;
    logic [15:0] rd_log [8];

    assign hpi_din = 16'hA000 + rd_idx;

    always @(negedge clk) begin
        #1;
        if (mon_clr) begin
            cs_pulses <= 0; cs_low_total <= 0; cs_high_run <= 0; min_gap <= 99;
            w_low_total <= 0; r_low_total <= 0; rst_low_total <= 0; busy_cycles <= 0;
            both_low <= 0; rw_out <= 0; oe_bad <= 0; addr_bad <= 0; rd_cnt <= 0;
            w_seen <= 1'b0; w_first <= '0; w_last <= '0; rd_idx <= '0;
        end else begin
            if (!hpi_cs) begin
                if (cs_prev) begin
                    if (cs_pulses > 0 && cs_high_run < min_gap) min_gap <= cs_high_run;
                    cs_pulses   <= cs_pulses + 1;
                    cs_high_run <= 0;
                end
                cs_low_total <= cs_low_total + 1;
                if (hpi_addr != exp_addr) addr_bad <= addr_bad + 1;
            end else begin
                cs_high_run <= cs_high_run + 1;
            end
            if (!hpi_w) begin
                w_low_total <= w_low_total + 1;
                if (!w_seen) begin
                    w_first <= hpi_dout;
                    w_seen  <= 1'b1;
                end
                w_last <= hpi_dout;
                if (!hpi_oe) oe_bad <= oe_bad + 1;
            end
            if (!hpi_r) r_low_total <= r_low_total + 1;
            if (!hpi_r && !hpi_w) both_low <= both_low + 1;
            if ((!hpi_r || !hpi_w) && hpi_cs) rw_out <= rw_out + 1;
            if (!hpi_rst) rst_low_total <= rst_low_total + 1;
            if (busy) busy_cycles <= busy_cycles + 1;
            if (!r_prev && hpi_r) rd_idx <= rd_idx + 16'd1;
            if (rd_valid && rd_ready && rd_cnt < 8) begin
                rd_log[rd_cnt] <= rd_data;
                rd_cnt         <= rd_cnt + 1;
            end
        end
        cs_prev <= hpi_cs;
        r_prev  <= hpi_r;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy, 0);
    endtask

    task automatic issue(input logic wr, input logic [1:0] a, input logic [7:0] len);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_len = '0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
        hpi_rst_req = 1'b0; mon_clr = 1'b1; exp_addr = HPI_DATA;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_cs", hpi_cs, 1);
        chk("rst_r", hpi_r, 1);
        chk("rst_w", hpi_w, 1);
        chk("rst_reset_export", hpi_rst, 1);
        chk("rst_addr", hpi_addr, 0);
        chk("rst_dout", hpi_dout, 0);
        chk("rst_oe", hpi_oe, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_busy", busy, 0);
        reset_reset = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_reset", cmd_ready, 1);
        mon_clr = 1'b0;

        // Single write, ADDRESS register, 0x1234
        exp_addr = HPI_ADDR;
        issue(1'b1, HPI_ADDR, 8'd0);
        wr_valid = 1'b1; wr_data = 16'h1234;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t1_wr_ready", wr_ready, 1);
        @(negedge clk);
        wr_valid = 1'b0;
        chk("t1_cs_after_dwell", hpi_cs, 0);
        wait_idle("t1_idle_timeout");
        chk("t1_cs_pulses", cs_pulses, 1);
        chk("t1_cs_low", cs_low_total, 6);
        chk("t1_w_low", w_low_total, 4);
        chk("t1_r_low", r_low_total, 0);
        chk("t1_w_data", w_last, 16'h1234);
        chk("t1_oe_bad", oe_bad, 0);
        chk("t1_busy_cycles", busy_cycles, 9);
        chk("t1_addr", hpi_addr, HPI_ADDR);
        chk("t1_addr_bad", addr_bad, 0);
        clr();

        // Read burst of 4 from DATA
        exp_addr = HPI_DATA;
        issue(1'b0, HPI_DATA, 8'd3);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle("t2_idle_timeout");
        chk("t2_rd_cnt", rd_cnt, 4);
        chk("t2_rd0", rd_log[0], 16'hA000);
        chk("t2_rd1", rd_log[1], 16'hA001);
        chk("t2_rd2", rd_log[2], 16'hA002);
        chk("t2_rd3", rd_log[3], 16'hA003);
        chk("t2_cs_pulses", cs_pulses, 4);
        chk("t2_r_low", r_low_total, 16);
        chk("t2_w_low", w_low_total, 0);
        chk("t2_addr_bad", addr_bad, 0);
        chk("t2_min_gap", min_gap, 2);
        chk("t2_busy_cycles", busy_cycles, 32);
        chk("t2_both_low", both_low, 0);
        chk("t2_rw_out", rw_out, 0);
        clr();

        // Read of 2 with rd_ready held low after the first word
        rd_ready = 1'b0;
        issue(1'b0, HPI_DATA, 8'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!rd_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t3_rd_valid_timeout", rd_valid, 1);
        chk("t3_first_data", rd_data, 16'hA000);
        repeat (10) @(negedge clk);
        chk("t3_stall_cs", hpi_cs, 1);
        chk("t3_stall_r", hpi_r, 1);
        chk("t3_stall_pulses", cs_pulses, 1);
        chk("t3_stall_busy", busy, 1);
        chk("t3_stall_rd_valid", rd_valid, 1);
        rd_ready = 1'b1;
        wait_idle("t3_idle_timeout");
        @(negedge clk);
        chk("t3_cs_pulses", cs_pulses, 2);
        chk("t3_rd_cnt", rd_cnt, 2);
        chk("t3_rd1", rd_log[1], 16'hA001);
        clr();

        // Write burst of 2 with a 5-cycle gap on wr_valid
        exp_addr = HPI_MAILBOX;
        issue(1'b1, HPI_MAILBOX, 8'd1);
        wr_valid = 1'b1; wr_data = 16'h1111;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        wr_valid = 1'b0;
        n = 0;
        while (!wr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t4_wr_ready_timeout", wr_ready, 1);
        repeat (5) @(negedge clk);
        chk("t4_gap_cs", hpi_cs, 1);
        chk("t4_gap_pulses", cs_pulses, 1);
        chk("t4_gap_wr_ready", wr_ready, 1);
        wr_valid = 1'b1; wr_data = 16'h2222;
        @(negedge clk);
        wr_valid = 1'b0;
        wait_idle("t4_idle_timeout");
        chk("t4_cs_pulses", cs_pulses, 2);
        chk("t4_w_low", w_low_total, 8);
        chk("t4_w_first", w_first, 16'h1111);
        chk("t4_w_last", w_last, 16'h2222);
        chk("t4_oe_bad", oe_bad, 0);
        chk("t4_rw_out", rw_out, 0);
        chk("t4_addr_bad", addr_bad, 0);
        clr();

        // HPI reset request together with a command
        exp_addr = HPI_STATUS;
        issue(1'b0, HPI_STATUS, 8'd0);
        hpi_rst_req = 1'b1;
        #1;
        chk("t5_cmd_ready_rst_req", cmd_ready, 0);
        @(negedge clk);
        hpi_rst_req = 1'b0;
        chk("t5_reset_low", hpi_rst, 0);
        n = 0;
        while (!cmd_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("t5_hrst_cycles", n, 16);
        chk("t5_rst_low_total", rst_low_total, 16);
        chk("t5_no_cs_during_hrst", cs_pulses, 0);
        chk("t5_reset_released", hpi_rst, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle("t5_idle_timeout");
        chk("t5_cs_pulses", cs_pulses, 1);
        chk("t5_rd_cnt", rd_cnt, 1);
        clr();

        // Synchronous reset during the strobe of word 2 of 4
        exp_addr = HPI_DATA;
        issue(1'b0, HPI_DATA, 8'd3);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!(hpi_r == 1'b0 && cs_pulses == 2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t6_strobe2_timeout", (hpi_r == 1'b0 && cs_pulses == 2), 1);
        reset_reset = 1'b1;
        @(negedge clk);
        chk("t6_cs", hpi_cs, 1);
        chk("t6_r", hpi_r, 1);
        chk("t6_w", hpi_w, 1);
        chk("t6_reset_export", hpi_rst, 1);
        chk("t6_busy", busy, 0);
        chk("t6_rd_valid", rd_valid, 0);
        chk("t6_oe", hpi_oe, 0);
        chk("t6_cmd_ready_in_reset", cmd_ready, 0);
        reset_reset = 1'b0;
        @(negedge clk);
        chk("t6_cmd_ready_after", cmd_ready, 1);
        repeat (5) @(negedge clk);
        chk("t6_abandoned", cs_pulses, 2);
        chk("t6_busy_after", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
